// File: rtl/pool2_pkg.sv
// Shared types and helpers for the 2x2 max-pool layer.
package pool2_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int SMAX_W         = 64;

  typedef enum logic {FILL = 1'b0, EMIT = 1'b1} phase_t;

  // Callers sign-extend narrower pixels into SMAX_W and cast the result back.
  function automatic logic signed [SMAX_W-1:0] smax(input logic signed [SMAX_W-1:0] a,
                                                    input logic signed [SMAX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool2_linebuf.sv
// Half-width line buffer: one write port, one registered read port, no reset.
module pool2_linebuf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 12,
  parameter int AW     = 4
) (
  input  logic              S_AXIS_ACLK,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge S_AXIS_ACLK) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/pool2_maxpool_core.sv
// 2x2 stride-2 max-pool over a raster-order AXI-Stream frame with a registered master output.
module pool2_maxpool_core
  import pool2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24
) (
  input  logic              S_AXIS_ACLK,
  input  logic              S_AXIS_ARESETN,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              frame_done,
  output logic              err_tlast
);

  localparam int CW    = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int DEPTH = IMG_W / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] col_reg, col_next;
  logic [RW-1:0] row_reg, row_next;
  phase_t        phase_reg, phase_next;

  logic signed [DATA_W-1:0] hold_reg;
  logic [DATA_W-1:0]        m_data_reg;
  logic                     m_valid_reg, m_last_reg, err_reg;

  logic accept, last_col, last_row, last_pos, early_last;
  logic hold_we, lb_we, lb_re, out_load;
  logic [AW-1:0]            lb_addr;
  logic [DATA_W-1:0]        lb_rdata;
  logic signed [DATA_W-1:0] pair_max, win_max;

  assign s_axis_tready = !m_valid_reg || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign last_col      = (col_reg == CW'(IMG_W - 1));
  assign last_row      = (row_reg == RW'(IMG_H - 1));
  assign last_pos      = last_col && last_row;
  assign early_last    = s_axis_tlast && !last_pos;
  assign lb_addr       = AW'(col_reg >> 1);

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      col_reg   <= '0;
      row_reg   <= '0;
      phase_reg <= FILL;
    end else begin
      col_reg   <= col_next;
      row_reg   <= row_next;
      phase_reg <= phase_next;
    end
  end

  always_comb begin
    col_next   = col_reg;
    row_next   = row_reg;
    phase_next = phase_reg;
    if (accept) begin
      if (early_last) begin
        col_next = '0;
        row_next = '0;
      end else if (last_col) begin
        col_next = '0;
        row_next = last_row ? '0 : row_reg + 1'b1;
      end else begin
        col_next = col_reg + 1'b1;
      end
      phase_next = row_next[0] ? EMIT : FILL;
    end
  end

  always_comb begin
    hold_we  = accept && !col_reg[0];
    lb_we    = accept && (phase_reg == FILL) && col_reg[0];
    lb_re    = accept && (phase_reg == EMIT) && !col_reg[0];
    out_load = accept && (phase_reg == EMIT) && col_reg[0];
  end

  assign pair_max = DATA_W'(smax(SMAX_W'(hold_reg), SMAX_W'(signed'(s_axis_tdata))));
  assign win_max  = DATA_W'(smax(SMAX_W'(pair_max), SMAX_W'(signed'(lb_rdata))));

  pool2_linebuf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_linebuf (
    .S_AXIS_ACLK (S_AXIS_ACLK),
    .we          (lb_we),
    .waddr       (lb_addr),
    .wdata       (pair_max),
    .re          (lb_re),
    .raddr       (lb_addr),
    .rdata       (lb_rdata)
  );

  // Output register refills on the same edge it drains, giving one beat per cycle.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      hold_reg    <= '0;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_last_reg  <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      if (hold_we) hold_reg <= s_axis_tdata;
      if (out_load) begin
        m_data_reg <= win_max;
        m_last_reg <= last_pos;
      end
      if (out_load)           m_valid_reg <= 1'b1;
      else if (m_axis_tready) m_valid_reg <= 1'b0;
      err_reg <= accept && (s_axis_tlast != last_pos);
    end
  end

  assign m_axis_tdata  = m_data_reg;
  assign m_axis_tvalid = m_valid_reg;
  assign m_axis_tlast  = m_last_reg;
  assign err_tlast     = err_reg;
  assign frame_done    = m_valid_reg && m_axis_tready && m_last_reg;

endmodule

// File: doc/pool2_maxpool_core.md
Name: pool2_maxpool_core

Overview:
- Datapath for the second pooling layer: 2x2 max-pool, stride 2, on a single-channel raster-order AXI-Stream feature map.
- Sits between the conv-layer output stream and the next layer's input.
- Holds one half-width line buffer, its own row/column counters and an AXI-Stream master output register with backpressure.
- Emits one pooled pixel per 2x2 window and marks the last pooled pixel of each frame with TLAST.

Parameters:
- DATA_W, 16, signed two's-complement pixel width.
- IMG_W, 24, input frame width in pixels. Must be even and >= 2.
- IMG_H, 24, input frame height in pixels. Must be even and >= 2.

Ports:
- S_AXIS_ACLK  in  1  clock.
- S_AXIS_ARESETN  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_W  input pixel.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last pixel of input frame.
- m_axis_tdata  out  DATA_W  pooled pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last pooled pixel of frame.
- frame_done  out  1  one-cycle pulse when the output TLAST beat transfers.
- err_tlast  out  1  one-cycle pulse on input TLAST mismatch.

Behaviour:
- Reset (asynchronous, active low): col=0, row=0, hold register=0, phase=FILL; m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, frame_done=0, err_tlast=0. Line buffer contents are not reset.
- Accept: a beat is accepted when s_axis_tvalid and s_axis_tready are both high. s_axis_tready = !m_axis_tvalid || m_axis_tready (combinational).
- Counters: col advances on each accepted beat and wraps at IMG_W-1. row advances on col wrap and wraps at IMG_H-1.
- phase: FILL when row is even, EMIT when row is odd.
- FILL, even col: latch the pixel into the hold register.
- FILL, odd col: write smax(hold, pixel) to linebuf[col>>1].
- EMIT, even col: latch the pixel into the hold register and issue a synchronous read of linebuf[col>>1].
- EMIT, odd col: load smax(hold, pixel, rd_data) into the output register. m_axis_tvalid rises the next cycle, so latency is 1 cycle from acceptance of the window's last pixel.
- m_axis_tlast=1 on the output beat produced from input pixel (IMG_H-1, IMG_W-1).
- smax: signed comparison. Ties resolve to either operand (values are equal).
- Output register holds data, valid and last stable until m_axis_tready. Simultaneous drain and refill in the same cycle is allowed, so sustained throughput is 1 pixel/cycle.
- Input TLAST, early: TLAST on an accepted beat that is not the last frame position:
  - err_tlast pulses.
  - col, row and phase resync to 0/FILL.
  - No output is produced for that beat unless it completes an EMIT window, in which case the output carries m_axis_tlast=0.
- Input TLAST, missing: no TLAST on the last frame position:
  - err_tlast pulses.
  - Counters wrap normally.
  - Output TLAST is still asserted (counters are authoritative).
- frame_done pulses on the cycle m_axis_tvalid && m_axis_tready && m_axis_tlast.
- Reset mid-frame discards any partial window and any pending output beat. The next frame is processed from position (0,0).

Decomposition:
- Package pool2_pkg: DATA_W default, smax function, phase enum {FILL, EMIT}.
- Sub-module pool2_linebuf: simple dual-port RAM, IMG_W/2 x DATA_W, one write port, one synchronous-read port, no reset.

Test Plan (IMG_W=4, IMG_H=4):
- Basic frame: pixels 0..15 row-major, TLAST on 15, m_axis_tready=1 -> outputs 5,7,13,15; tlast only on 15; frame_done once; err_tlast never.
- Signed data: pixel i = -(i+1) -> outputs -1,-3,-9,-11.
- Backpressure: hold m_axis_tready=0 for 5 cycles after the first output valid -> m_axis_tdata stays 5, s_axis_tready=0 throughout, then 7,13,15 follow with no loss or duplication.
- Early TLAST on pixel 6 -> err_tlast pulses once. The following clean frame 0..15 yields 5,7,13,15 with tlast on 15.
- Missing TLAST on pixel 15 -> err_tlast pulses; output 15 still carries m_axis_tlast=1; frame_done pulses.
- Reset asserted after 9 accepted pixels -> all outputs at reset values. A following clean frame 0..15 yields 5,7,13,15.
